config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 237 +++++++++++++++++++++++
 tb/tb_config_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//
// Receives a 16-bit serial configuration frame and switches a downstream
// 2x2 selector stage to a new configuration code. Output enables are gated
// off around the change, so the selector never switches while enables pass.
//
// Frame layout (MSB first): [15:8] sync = 0xA5, [7:4] new code,
// [3:0] check = bitwise inverse of the code.
//
// Serial handshake: a bit transfers on a rising clock edge only when
// ser_en=1 and ser_strobe=1 in the same cycle. ser_strobe is a one-cycle
// qualifier and there is no back-pressure. ser_en frames the transfer: it
// rises to start a frame, and it must fall before the next frame can begin.
//
// Parameters
//   QUIESCE_CYCLES  oe-gated cycles before and after the change (1..15)
//   MAX_CONFIG      largest accepted configuration code
//
// Ports
//   clk            in   sole clock; all logic on the rising edge
//   rst            in   synchronous active-high reset
//   ser_en         in   frame enable
//   ser_data       in   serial bit, used only when ser_strobe=1
//   ser_strobe     in   bit-valid qualifier
//   configuration  out  registered code driving the selector stage
//   oe_gate        out  1 = output enables may pass, 0 = forced low
//   busy           out  high whenever the FSM is not in IDLE
//   cfg_done       out  one-cycle pulse: frame accepted, switchover complete
//   cfg_err        out  one-cycle pulse: frame rejected or aborted
//   dbg_state      out  current FSM state encoding (observation only)
//
// Build option
//   CFG_LOADER_LOCK_EN  when defined, the first cfg_done sets a sticky lock.
//                       While the lock is set, every later frame is rejected.
//                       Only rst clears the lock.
// -----------------------------------------------------------------------------
module config_loader #(
    parameter int QUIESCE_CYCLES = 4,
    parameter int MAX_CONFIG     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ser_en,
    input  logic       ser_data,
    input  logic       ser_strobe,
    output logic [3:0] configuration,
    output logic       oe_gate,
    output logic       busy,
    output logic       cfg_done,
    output logic       cfg_err,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SHIFT    = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_QUIESCE  = 3'd3;
    localparam logic [2:0] S_APPLY    = 3'd4;
    localparam logic [2:0] S_SETTLE   = 3'd5;
    localparam logic [2:0] S_WAIT_LOW = 3'd6;

    localparam logic [7:0] SYNC_WORD = 8'hA5;
    localparam logic [3:0] Q_LAST    = 4'(QUIESCE_CYCLES - 1);
    localparam logic [3:0] MAX_CODE  = 4'(MAX_CONFIG);

    logic [2:0]  state_q, state_d;
    logic [15:0] sr_q, sr_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic [3:0]  qcnt_q, qcnt_d;
    logic [3:0]  cfg_q, cfg_d;
    logic        oe_q, oe_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        locked;

    logic [7:0]  frm_sync;
    logic [3:0]  frm_code;
    logic [3:0]  frm_check;
    logic        frame_ok;

    assign frm_sync  = sr_q[15:8];
    assign frm_code  = sr_q[7:4];
    assign frm_check = sr_q[3:0];

    assign frame_ok = (frm_sync == SYNC_WORD) &&
                      (frm_check == ~frm_code) &&
                      (frm_code <= MAX_CODE) &&
                      !locked;

`ifdef CFG_LOADER_LOCK_EN
    logic lock_q, lock_d;

    // The lock is sticky. Any cfg_done sets it, including a done for a frame
    // that repeats the current code.
    always_comb begin
        lock_d = lock_q | done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end

    assign locked = lock_q;
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        bitcnt_d = bitcnt_q;
        qcnt_d   = qcnt_q;
        cfg_d    = cfg_q;
        oe_d     = oe_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ser_en) begin
                    state_d  = S_SHIFT;
                    sr_d     = 16'd0;
                    bitcnt_d = 4'd0;
                    // A strobe in the enabling cycle is the first frame bit.
                    if (ser_strobe) begin
                        sr_d     = {15'd0, ser_data};
                        bitcnt_d = 4'd1;
                    end
                end
            end

            S_SHIFT: begin
                if (!ser_en) begin
                    // The frame is truncated, so any coinciding strobe is dropped.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (ser_strobe) begin
                    sr_d     = {sr_q[14:0], ser_data};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd15) begin
                        state_d = S_CHECK;
                    end
                end
            end

            S_CHECK: begin
                if (!frame_ok) begin
                    err_d   = 1'b1;
                    state_d = S_WAIT_LOW;
                end else if (frm_code == cfg_q) begin
                    // No change is needed, so the output enables are never gated.
                    done_d  = 1'b1;
                    state_d = S_WAIT_LOW;
                end else begin
                    oe_d    = 1'b0;
                    qcnt_d  = 4'd0;
                    state_d = S_QUIESCE;
                end
            end

            S_QUIESCE: begin
                if (qcnt_q == Q_LAST) begin
                    qcnt_d  = 4'd0;
                    state_d = S_APPLY;
                end else begin
                    qcnt_d = qcnt_q + 4'd1;
                end
            end

            S_APPLY: begin
                // The shift register is frozen outside IDLE/SHIFT, so the code is still valid.
                cfg_d   = frm_code;
                qcnt_d  = 4'd0;
                state_d = S_SETTLE;
            end

            S_SETTLE: begin
                if (qcnt_q == Q_LAST) begin
                    // oe_gate rises in the same cycle as the done pulse.
                    oe_d    = 1'b1;
                    done_d  = 1'b1;
                    qcnt_d  = 4'd0;
                    state_d = S_WAIT_LOW;
                end else begin
                    qcnt_d = qcnt_q + 4'd1;
                end
            end

            S_WAIT_LOW: begin
                // Strobes are ignored here, so bits after the 16th cannot start a frame.
                if (!ser_en) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                oe_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sr_q     <= 16'd0;
            bitcnt_q <= 4'd0;
            qcnt_q   <= 4'd0;
            cfg_q    <= 4'd0;
            oe_q     <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            bitcnt_q <= bitcnt_d;
            qcnt_q   <= qcnt_d;
            cfg_q    <= cfg_d;
            oe_q     <= oe_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign configuration = cfg_q;
    assign oe_gate       = oe_q;
    assign busy          = (state_q != S_IDLE);
    assign cfg_done      = done_q;
    assign cfg_err       = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader
//
// Self-checking bench for config_loader. It runs in four phases:
//   1. A table of directed frames, each with hand-derived expected outcomes.
//   2. Hand-written multi-cycle sequences:
//        - reset during SETTLE
//        - ser_en already high at reset release
//        - extra bits after the 16th bit
//   3. Random frames checked against a transaction-level reference model.
//   4. A single summary line.
//
// Outcomes are expected to differ when CFG_LOADER_LOCK_EN is defined, and the
// bench expectations follow the same macro.
// -----------------------------------------------------------------------------
module tb_config_loader;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ser_en = 1'b0;
    logic       ser_data = 1'b0;
    logic       ser_strobe = 1'b0;
    logic [3:0] configuration;
    logic       oe_gate;
    logic       busy;
    logic       cfg_done;
    logic       cfg_err;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    config_loader #(.QUIESCE_CYCLES(Q), .MAX_CONFIG(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .ser_en       (ser_en),
        .ser_data     (ser_data),
        .ser_strobe   (ser_strobe),
        .configuration(configuration),
        .oe_gate      (oe_gate),
        .busy         (busy),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .dbg_state    (dbg_state)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Observations accumulated per transaction.
    int obs_low, obs_done, obs_err, obs_both, obs_hi_chg, obs_chg_idx, obs_rise_done;
    logic [3:0] prev_cfg = 4'd0;
    logic       prev_oe  = 1'b1;

    // Reference model state and the scoreboard queue of expected configurations.
    int         model_cfg  = 0;
    bit         model_lock = 1'b0;
    logic [3:0] exp_q[$];

    typedef struct {
        bit          do_rst;
        logic [15:0] frame;
        int          nbits;
        int          e_err;
        int          e_done;
        int          e_low;
        int          e_cfg;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (cfg_done && cfg_err) obs_both++;
        if (configuration != prev_cfg && oe_gate) obs_hi_chg++;
        if (!oe_gate) begin
            if (configuration != prev_cfg && obs_chg_idx < 0) obs_chg_idx = obs_low;
            obs_low++;
        end
        if (cfg_done) begin
            obs_done++;
            if (oe_gate && !prev_oe) obs_rise_done++;
        end
        if (cfg_err) obs_err++;
        prev_cfg = configuration;
        prev_oe  = oe_gate;
    endtask

    task automatic start_txn();
        obs_low       = 0;
        obs_done      = 0;
        obs_err       = 0;
        obs_both      = 0;
        obs_hi_chg    = 0;
        obs_chg_idx   = -1;
        obs_rise_done = 0;
    endtask

    task automatic do_reset(input bit hold_en);
        rst        = 1'b1;
        ser_en     = hold_en;
        ser_strobe = 1'b0;
        ser_data   = 1'b0;
        tick();
        tick();
        chk("reset configuration", int'(configuration), 0);
        chk("reset oe_gate", int'(oe_gate), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset cfg_done", int'(cfg_done), 0);
        chk("reset cfg_err", int'(cfg_err), 0);
        rst        = 1'b0;
        model_cfg  = 0;
        model_lock = 1'b0;
        exp_q.delete();
    endtask

    // Shift nbits of frame f MSB first, with 0..maxgap idle cycles before each bit.
    task automatic shift_frame(input logic [15:0] f, input int nbits, input int maxgap);
        int gap;
        ser_en = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            gap = $urandom_range(0, maxgap);
            for (int g = 0; g < gap; g++) begin
                ser_strobe = 1'b0;
                ser_data   = 1'($urandom_range(0, 1));
                tick();
            end
            ser_strobe = 1'b1;
            ser_data   = f[15 - i];
            tick();
        end
        ser_strobe = 1'b0;
    endtask

    // Drop ser_en and wait, within a cycle budget, for the FSM to reach IDLE.
    task automatic finish_frame(input bit strobe_on_drop);
        int c;
        bit idle_seen;
        c          = 0;
        idle_seen  = 1'b0;
        ser_en     = 1'b0;
        ser_strobe = strobe_on_drop;
        ser_data   = 1'b1;
        while (!idle_seen && c < 6 * Q + 20) begin
            tick();
            ser_strobe = 1'b0;
            c++;
            if (!busy) idle_seen = 1'b1;
        end
        chk("return to idle", int'(idle_seen), 1);
    endtask

    task automatic check_txn(input string tag, input int e_err, input int e_done,
                             input int e_low, input int e_cfg);
        chk({tag, " cfg_err pulses"}, obs_err, e_err);
        chk({tag, " cfg_done pulses"}, obs_done, e_done);
        chk({tag, " oe_gate low cycles"}, obs_low, e_low);
        chk({tag, " configuration"}, int'(configuration), e_cfg);
        chk({tag, " done+err same cycle"}, obs_both, 0);
        chk({tag, " cfg change while oe high"}, obs_hi_chg, 0);
        chk({tag, " busy at end"}, int'(busy), 0);
        chk({tag, " done on oe rise"}, obs_rise_done, (e_low > 0) ? 1 : 0);
        // Q quiesce cycles and the APPLY cycle are low before the new code shows.
        if (e_low > 0) chk({tag, " cfg change low index"}, obs_chg_idx, Q + 1);
    endtask

    // Transaction-level model: decide the outcome directly from the frame rules.
    task automatic model_frame(input logic [15:0] f, input int nbits,
                               output int e_err, output int e_done, output int e_low);
        logic [3:0] code;
        logic [3:0] inv;
        code   = f[7:4];
        inv    = ~code;
        e_err  = 0;
        e_done = 0;
        e_low  = 0;
        if (nbits < 16) begin
            e_err = 1;
        end else if (f[15:8] != 8'hA5 || f[3:0] != inv || int'(code) > 3 || model_lock) begin
            e_err = 1;
        end else begin
            e_done = 1;
            if (int'(code) != model_cfg) begin
                e_low     = 2 * Q + 1;
                model_cfg = int'(code);
            end
`ifdef CFG_LOADER_LOCK_EN
            model_lock = 1'b1;
`endif
        end
        exp_q.push_back(4'(model_cfg));
    endtask

    initial begin
        int c;
        int e_err, e_done, e_low;
        int kind, nb;
        logic [3:0] code;
        logic [15:0] f;
        logic [3:0] e_cfg;

        // Directed table: {reset first, frame, bits, err, done, low cycles, final cfg}.
        tbl[0] = '{1'b1, 16'hA52D, 16, 0, 1, 2 * Q + 1, 2};
        tbl[1] = '{1'b0, 16'hA51F, 16, 1, 0, 0, 2};
        tbl[2] = '{1'b0, 16'hA54B, 16, 1, 0, 0, 2};
        tbl[3] = '{1'b0, 16'h5A2D, 16, 1, 0, 0, 2};
        tbl[4] = '{1'b1, 16'hA52D,  9, 1, 0, 0, 0};
        tbl[5] = '{1'b0, 16'hA52D, 16, 0, 1, 2 * Q + 1, 2};
`ifdef CFG_LOADER_LOCK_EN
        tbl[6] = '{1'b0, 16'hA52D, 16, 1, 0, 0, 2};
`else
        tbl[6] = '{1'b0, 16'hA52D, 16, 0, 1, 0, 2};
`endif
        tbl[7] = '{1'b1, 16'hA51E, 16, 0, 1, 2 * Q + 1, 1};
`ifdef CFG_LOADER_LOCK_EN
        tbl[8] = '{1'b0, 16'hA53C, 16, 1, 0, 0, 1};
`else
        tbl[8] = '{1'b0, 16'hA53C, 16, 0, 1, 2 * Q + 1, 3};
`endif

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].do_rst) do_reset(1'b0);
            start_txn();
            shift_frame(tbl[i].frame, tbl[i].nbits, 2);
            finish_frame(1'b0);
            check_txn($sformatf("row%0d", i), tbl[i].e_err, tbl[i].e_done,
                      tbl[i].e_low, tbl[i].e_cfg);
        end

        // Reset while in SETTLE, after the new code is already visible.
        do_reset(1'b0);
        start_txn();
        shift_frame(16'hA52D, 16, 1);
        ser_en = 1'b0;
        c = 0;
        while (obs_low < Q + 2 && c < 50) begin
            tick();
            c++;
        end
        chk("settle reached", obs_low, Q + 2);
        chk("settle configuration", int'(configuration), 2);
        rst = 1'b1;
        tick();
        chk("settle rst configuration", int'(configuration), 0);
        chk("settle rst oe_gate", int'(oe_gate), 1);
        chk("settle rst busy", int'(busy), 0);
        chk("settle rst cfg_done", int'(cfg_done), 0);
        rst = 1'b0;
        start_txn();
        repeat (3 * Q) tick();
        chk("post rst cfg_done pulses", obs_done, 0);
        chk("post rst oe low cycles", obs_low, 0);
        chk("post rst configuration", int'(configuration), 0);

        // ser_en is already high at reset release, and the first strobe lands in that cycle.
        do_reset(1'b1);
        start_txn();
        shift_frame(16'hA52D, 16, 0);
        finish_frame(1'b0);
        check_txn("en held through rst", 0, 1, 2 * Q + 1, 2);

        // Extra strobes after the 16th bit, with ser_en held high.
        do_reset(1'b0);
        start_txn();
        shift_frame(16'hA51E, 16, 1);
        for (int k = 0; k < 3 * Q + 10; k++) begin
            ser_strobe = 1'($urandom_range(0, 1));
            ser_data   = 1'($urandom_range(0, 1));
            tick();
        end
        ser_strobe = 1'b0;
        finish_frame(1'b0);
        check_txn("extra bits", 0, 1, 2 * Q + 1, 1);

        // Randomized frames checked against the model.
        do_reset(1'b0);
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 9);
            code = 4'($urandom_range(0, 3));
            nb   = 16;
            f    = {8'hA5, code, ~code};
            if (kind == 6) begin
                code = 4'($urandom_range(4, 15));
                f    = {8'hA5, code, ~code};
            end else if (kind == 7) begin
                f = 16'($urandom_range(0, 65535));
            end else if (kind == 8) begin
                nb = $urandom_range(1, 15);
            end else if (kind == 9) begin
                do_reset(1'b0);
            end
            model_frame(f, nb, e_err, e_done, e_low);
            start_txn();
            shift_frame(f, nb, 2);
            finish_frame(1'($urandom_range(0, 1)));
            e_cfg = exp_q.pop_front();
            check_txn($sformatf("rand%0d", k), e_err, e_done, e_low, int'(e_cfg));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
